cell_link_pkt_arbiter: RTL and testbench
========================================

CELL_LINK_PKT_ARBITER -- requirements
Module: cell_link_pkt_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, giving the TDATA width of all streams.
REQ-002 The block SHALL have parameter MAXLEN, default 64, giving the maximum forwarded packet length in beats (range 2..4096).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-004 Port ACLK, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 Port ARESETN, input, 1 bit: asynchronous active-low reset.
REQ-006 Ports S00_AXIS_TVALID/TREADY/TDATA/TLAST, in/out/in/in, widths 1/1/DW/1: source 0 stream.
REQ-007 Ports S01_AXIS_TVALID/TREADY/TDATA/TLAST, in/out/in/in, widths 1/1/DW/1: source 1 stream.
REQ-008 Ports M00_AXIS_TVALID/TREADY/TDATA/TLAST, out/in/out/out, widths 1/1/DW/1: merged output stream.
REQ-009 Ports S00_ARB_REQ_SUPPRESS and S01_ARB_REQ_SUPPRESS, input, 1 bit each: mask the new-packet request of the matching source.
REQ-010 Ports PKT_COUNT00 and PKT_COUNT01, output, 16 bits each: packets completed per source, wrapping.
REQ-011 Port TRUNC_FLAG, output, 2 bits: sticky per-source truncation flags (bit 0 is S00).
REQ-012 Port TRUNC_CLEAR, input, 1 bit: synchronous clear of TRUNC_FLAG.

Function
REQ-013 The FSM SHALL have states IDLE, GRANT0, GRANT1, DRAIN0 and DRAIN1.
REQ-014 In IDLE, the request of source n SHALL be Sn_TVALID AND NOT Sn_ARB_REQ_SUPPRESS.
REQ-015 In IDLE, with a single request, the FSM SHALL enter the GRANT state of that source on the next edge.
REQ-016 In IDLE, with both sources requesting, the FSM SHALL grant the source not recorded in last_served (round robin).
REQ-017 IDLE SHALL last exactly one cycle per packet: arbitration latency is 1 cycle and no beat is transferred in IDLE.
REQ-018 In GRANTn, M00_AXIS_TVALID, TDATA and TLAST SHALL be driven combinationally from source n, and Sn_AXIS_TREADY SHALL equal M00_AXIS_TREADY.
REQ-019 In GRANTn, the other source's TREADY SHALL be 0.
REQ-020 In IDLE and DRAINn, M00_AXIS_TVALID SHALL be 0.
REQ-021 A beat SHALL count as transferred only when both VALID and READY are high; a beat counter (clog2(MAXLEN)+1 bits) SHALL increment per transferred beat and clear on each grant.
REQ-022 On a transferred beat with source TLAST=1 in GRANTn, the FSM SHALL:
- set last_served to n;
- increment PKT_COUNTn modulo 2^16;
- return to IDLE.
REQ-023 If beat MAXLEN of a granted packet transfers with source TLAST=0, the FSM SHALL:
- force M00_AXIS_TLAST=1 on that beat;
- set TRUNC_FLAG[n];
- increment PKT_COUNTn;
- set last_served to n;
- enter DRAINn.
REQ-024 In DRAINn, Sn_AXIS_TREADY SHALL be 1 and accepted beats SHALL be discarded; the FSM SHALL enter IDLE after the beat with Sn_TLAST=1.
REQ-025 Suppress inputs SHALL affect only IDLE arbitration and SHALL NOT abort a packet already in GRANTn or DRAINn.
REQ-026 A request that is dropped in IDLE (VALID falls or suppress rises before the edge) SHALL NOT produce a grant.
REQ-027 If TRUNC_CLEAR and a new truncation coincide, the set SHALL win for that bit.
REQ-028 Stalls on M00_AXIS_TREADY=0 SHALL hold state, the beat counter and all outputs stable.

Reset
REQ-029 While ARESETN=0, the block SHALL hold:
- state IDLE;
- last_served=1, so S00 wins first contention;
- beat counter 0, PKT_COUNT00/01 0, TRUNC_FLAG 0;
- all TREADY outputs 0 and M00_AXIS_TVALID 0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet with no forced TLAST, and arbitration SHALL restart from IDLE after release.

Verification
REQ-031 S00 16-beat packet, TREADY=1 -> 16 beats out after 1 idle cycle, last beat has TLAST, PKT_COUNT00=1.
REQ-032 S00 and S01 each continuously offer 8-beat packets -> output alternates S00, S01, S00, ...; no interleaving within a packet; counters equal after each pair.
REQ-033 S01 offers a 70-beat packet with MAXLEN=64 -> 64 beats out with TLAST on beat 64, 6 beats drained, TRUNC_FLAG=2'b10, then TRUNC_CLEAR -> 2'b00.
REQ-034 S00_ARB_REQ_SUPPRESS=1 while both sources are valid -> only S01 is granted; deasserting suppress mid-S01-packet -> S00 is granted only after that packet's TLAST.
REQ-035 M00_AXIS_TREADY toggling pseudo-randomly during a 16-beat packet -> data sequence intact and outputs stable during stalls.
REQ-036 ARESETN pulsed low at beat 5 of a packet -> counters 0, TVALID 0; after release the next packet is forwarded normally.

Source files
------------

// File: rtl/cell_link_pkt_arbiter_if.sv
// AXI4-Stream channel bundle shared by the two source ports and the merged output
// of the packet arbiter.
interface cell_link_pkt_arbiter_if #(
    parameter int DW = 32
);
    logic          TVALID;
    logic          TREADY;
    logic [DW-1:0] TDATA;
    logic          TLAST;

    modport master (output TVALID, TDATA, TLAST, input TREADY);
    modport slave  (input TVALID, TDATA, TLAST, output TREADY);
endinterface

// File: rtl/cell_link_pkt_arbiter.sv
// Two-source packet-granular AXI-Stream arbiter with round-robin contention, per-source
// request masking, packet counters and length truncation with drain of the overflow.
module cell_link_pkt_arbiter #(
    parameter int DW     = 32,
    parameter int MAXLEN = 64
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    cell_link_pkt_arbiter_if.slave         S00_AXIS,
    cell_link_pkt_arbiter_if.slave         S01_AXIS,
    cell_link_pkt_arbiter_if.master        M00_AXIS,
    input  logic                           S00_ARB_REQ_SUPPRESS,
    input  logic                           S01_ARB_REQ_SUPPRESS,
    output logic [15:0]                    PKT_COUNT00,
    output logic [15:0]                    PKT_COUNT01,
    output logic [1:0]                     TRUNC_FLAG,
    input  logic                           TRUNC_CLEAR
);
    localparam int CW = $clog2(MAXLEN) + 1;

    typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, DRAIN0, DRAIN1} state_t;

    state_t        state, state_next;
    logic          last_served, last_served_next;
    logic [CW-1:0] beat_cnt, beat_cnt_next;
    logic [1:0]    pkt_done, trunc_set;
    logic [1:0]    s_valid, s_last, s_ready, req;
    logic [DW-1:0] s_data [2];
    logic          sel, at_max;

    assign s_valid = {S01_AXIS.TVALID, S00_AXIS.TVALID};
    assign s_last  = {S01_AXIS.TLAST, S00_AXIS.TLAST};
    assign s_data[0] = S00_AXIS.TDATA;
    assign s_data[1] = S01_AXIS.TDATA;
    assign req     = s_valid & ~{S01_ARB_REQ_SUPPRESS, S00_ARB_REQ_SUPPRESS};
    assign S00_AXIS.TREADY = s_ready[0];
    assign S01_AXIS.TREADY = s_ready[1];

    // The current beat is the MAXLEN-th of the packet when MAXLEN-1 beats have gone.
    assign at_max = (beat_cnt == CW'(MAXLEN - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next       = state;
        last_served_next = last_served;
        beat_cnt_next    = beat_cnt;
        pkt_done         = 2'b00;
        trunc_set        = 2'b00;
        s_ready          = 2'b00;
        sel              = 1'b0;
        M00_AXIS.TVALID  = 1'b0;
        M00_AXIS.TDATA   = '0;
        M00_AXIS.TLAST   = 1'b0;

        unique case (state)
            IDLE: begin
                beat_cnt_next = '0;
                if (req == 2'b11)  state_next = last_served ? GRANT0 : GRANT1;
                else if (req[0])   state_next = GRANT0;
                else if (req[1])   state_next = GRANT1;
            end
            GRANT0, GRANT1: begin
                sel             = (state == GRANT1);
                M00_AXIS.TVALID = s_valid[sel];
                M00_AXIS.TDATA  = s_data[sel];
                M00_AXIS.TLAST  = s_last[sel] | at_max;
                s_ready[sel]    = M00_AXIS.TREADY;
                if (s_valid[sel] && M00_AXIS.TREADY) begin
                    beat_cnt_next = beat_cnt + CW'(1);
                    if (s_last[sel] || at_max) begin
                        pkt_done[sel]    = 1'b1;
                        last_served_next = sel;
                        if (s_last[sel]) begin
                            state_next = IDLE;
                        end else begin
                            // Overflowing packet: close it downstream, swallow the rest.
                            trunc_set[sel] = 1'b1;
                            state_next     = sel ? DRAIN1 : DRAIN0;
                        end
                    end
                end
            end
            DRAIN0, DRAIN1: begin
                sel          = (state == DRAIN1);
                s_ready[sel] = 1'b1;
                if (s_valid[sel] && s_last[sel]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= IDLE;
            last_served <= 1'b1;
            beat_cnt    <= '0;
            PKT_COUNT00 <= '0;
            PKT_COUNT01 <= '0;
            TRUNC_FLAG  <= 2'b00;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            state       <= state_next;
            last_served <= last_served_next;
            beat_cnt    <= beat_cnt_next;
            PKT_COUNT00 <= PKT_COUNT00 + 16'(pkt_done[0]);
            PKT_COUNT01 <= PKT_COUNT01 + 16'(pkt_done[1]);
            // A new truncation beats a simultaneous clear.
            TRUNC_FLAG  <= (TRUNC_FLAG & ~{2{TRUNC_CLEAR}}) | trunc_set;
        end
    end
endmodule

// File: tb/tb_cell_link_pkt_arbiter.sv
// Randomized scoreboard bench for cell_link_pkt_arbiter: a packet-level model predicts the
// merged beat stream and counters; a negedge monitor compares every accepted output beat.
module tb_cell_link_pkt_arbiter;
    localparam int DW     = 32;
    localparam int MAXLEN = 64;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        sup0, sup1, trunc_clear;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  trunc_flag;

    always #5 ACLK = ~ACLK;

    cell_link_pkt_arbiter_if #(.DW(DW)) s00_if ();
    cell_link_pkt_arbiter_if #(.DW(DW)) s01_if ();
    cell_link_pkt_arbiter_if #(.DW(DW)) m00_if ();

    cell_link_pkt_arbiter #(.DW(DW), .MAXLEN(MAXLEN)) dut (
        .ACLK                 (ACLK),
        .ARESETN              (ARESETN),
        .S00_AXIS             (s00_if.slave),
        .S01_AXIS             (s01_if.slave),
        .M00_AXIS             (m00_if.master),
        .S00_ARB_REQ_SUPPRESS (sup0),
        .S01_ARB_REQ_SUPPRESS (sup1),
        .PKT_COUNT00          (cnt0),
        .PKT_COUNT01          (cnt1),
        .TRUNC_FLAG           (trunc_flag),
        .TRUNC_CLEAR          (trunc_clear)
    );

    beat_t       exp_q [$];
    beat_t       src_q [2][$];
    int          src_len [2][$];
    int          tests = 0;
    int          fails = 0;
    int          mon_beats = 0;
    int          mdl_last;
    logic [15:0] exp_cnt [2];
    logic [1:0]  exp_trunc;
    logic        rand_ready = 1'b0;
    logic        abort [2];
    logic        timeout;
    logic        prev_stall = 1'b0;
    beat_t       prev_out, exp_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic set_src(input int s, input logic v, input logic [DW-1:0] d, input logic l);
        if (s == 0) begin
            s00_if.TVALID = v; s00_if.TDATA = d; s00_if.TLAST = l;
        end else begin
            s01_if.TVALID = v; s01_if.TDATA = d; s01_if.TLAST = l;
        end
    endtask

    function automatic logic get_ready(input int s);
        return (s == 0) ? s00_if.TREADY : s01_if.TREADY;
    endfunction

    task automatic gen_pkt(input int s, input int len);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.data = $urandom;
            x.last = (b == len - 1);
            src_q[s].push_back(x);
        end
        src_len[s].push_back(len);
    endtask

    // Packet-level model: round-robin between pending sources, truncation to MAXLEN.
    task automatic predict(input int blocked);
        int    pos [2];
        int    pk [2];
        int    s, len, kept;
        bit    have0, have1;
        beat_t x;
        pos = '{0, 0};
        pk  = '{0, 0};
        while (pk[0] < src_len[0].size() || pk[1] < src_len[1].size()) begin
            have0 = pk[0] < src_len[0].size();
            have1 = pk[1] < src_len[1].size();
            if (have0 && have1) s = (blocked >= 0) ? 1 - blocked : ((mdl_last == 1) ? 0 : 1);
            else                s = have0 ? 0 : 1;
            blocked = -1;
            len  = src_len[s][pk[s]];
            kept = (len > MAXLEN) ? MAXLEN : len;
            for (int b = 0; b < kept; b++) begin
                x      = src_q[s][pos[s] + b];
                x.last = (b == kept - 1);
                exp_q.push_back(x);
            end
            pos[s] += len;
            pk[s]++;
            mdl_last = s;
            exp_cnt[s] = exp_cnt[s] + 16'd1;
            if (len > MAXLEN) exp_trunc[s] = 1'b1;
        end
        src_len[0].delete();
        src_len[1].delete();
    endtask

    task automatic drive(input int s);
        beat_t x;
        logic  h;
        int    waited;
        while (src_q[s].size() > 0 && !abort[s]) begin
            x = src_q[s][0];
            set_src(s, 1'b1, x.data, x.last);
            h = 1'b0;
            waited = 0;
            while (!h && !abort[s]) begin
                @(negedge ACLK);
                h = get_ready(s) && ARESETN;
                @(posedge ACLK);
                #1;
                waited++;
                if (!h && waited > 2000) begin
                    timeout  = 1'b1;
                    abort[s] = 1'b1;
                end
            end
            if (h) void'(src_q[s].pop_front());
        end
        if (abort[s]) src_q[s].delete();
        set_src(s, 1'b0, '0, 1'b0);
    endtask

    task automatic model_reset();
        mdl_last   = 1;
        exp_cnt[0] = '0;
        exp_cnt[1] = '0;
        exp_trunc  = 2'b00;
        exp_q.delete();
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        set_src(0, 1'b1, '0, 1'b0);
        set_src(1, 1'b1, '0, 1'b0);
        repeat (2) @(negedge ACLK);
        check("reset_m_tvalid", m00_if.TVALID, 0);
        check("reset_s00_tready", s00_if.TREADY, 0);
        check("reset_s01_tready", s01_if.TREADY, 0);
        check("reset_cnt", {cnt1, cnt0}, 0);
        check("reset_trunc", trunc_flag, 0);
        set_src(0, 1'b0, '0, 1'b0);
        set_src(1, 1'b0, '0, 1'b0);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        model_reset();
    endtask

    task automatic end_scn(input string name);
        repeat (4) @(posedge ACLK);
        #1;
        check({name, "_all_beats_seen"}, exp_q.size(), 0);
        check({name, "_sources_done"}, src_q[0].size() + src_q[1].size(), 0);
        check({name, "_no_timeout"}, timeout, 0);
        check({name, "_pkt_count00"}, cnt0, exp_cnt[0]);
        check({name, "_pkt_count01"}, cnt1, exp_cnt[1]);
        check({name, "_trunc_flag"}, trunc_flag, exp_trunc);
        timeout = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 2000 && mon_beats < n; i++) begin
            @(posedge ACLK);
            #1;
        end
        check("beat_wait_bound", mon_beats >= n, 1);
    endtask

    initial begin : ready_gen
        m00_if.TREADY = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            m00_if.TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_valid", m00_if.TVALID, 1);
                    check("stall_hold_beat", {m00_if.TDATA, m00_if.TLAST}, prev_out);
                end
                if (m00_if.TVALID && m00_if.TREADY) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat",
                                 m00_if.TDATA, m00_if.TLAST);
                    end else begin
                        exp_beat = exp_q.pop_front();
                        check("out_beat", {m00_if.TDATA, m00_if.TLAST}, exp_beat);
                    end
                    mon_beats++;
                end
                prev_stall = m00_if.TVALID && !m00_if.TREADY;
                prev_out   = {m00_if.TDATA, m00_if.TLAST};
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not complete, expected summary");
        $fatal(1);
    end

    initial begin : main
        int base;
        sup0 = 1'b0;
        sup1 = 1'b0;
        trunc_clear = 1'b0;
        abort = '{1'b0, 1'b0};
        timeout = 1'b0;
        set_src(0, 1'b0, '0, 1'b0);
        set_src(1, 1'b0, '0, 1'b0);
        do_reset();

        // Single 16-beat packet: one idle cycle, then the packet.
        gen_pkt(0, 16);
        predict(-1);
        fork
            drive(0);
            begin
                @(negedge ACLK);
                check("idle_cycle_tvalid", m00_if.TVALID, 0);
                @(negedge ACLK);
                check("grant_latency_tvalid", m00_if.TVALID, 1);
                check("grant_other_tready", s01_if.TREADY, 0);
            end
        join
        end_scn("single");

        // Both sources back-to-back with random backpressure: strict alternation.
        do_reset();
        rand_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            gen_pkt(0, 8);
            gen_pkt(1, 8);
        end
        predict(-1);
        fork
            drive(0);
            drive(1);
        join
        rand_ready = 1'b0;
        end_scn("round_robin");

        // Oversized S01 packet; a clear coinciding with the truncation must lose.
        gen_pkt(1, MAXLEN + 6);
        predict(-1);
        fork
            drive(1);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge ACLK);
                    if (m00_if.TVALID && m00_if.TREADY && m00_if.TLAST) begin
                        trunc_clear = 1'b1;
                        @(posedge ACLK);
                        #1;
                        trunc_clear = 1'b0;
                        break;
                    end
                end
            end
        join
        end_scn("truncate");
        trunc_clear = 1'b1;
        @(posedge ACLK);
        #1;
        trunc_clear = 1'b0;
        exp_trunc = 2'b00;
        check("trunc_clear", trunc_flag, exp_trunc);

        // S00 suppressed while both are valid; releasing it mid-packet must not preempt S01.
        sup0 = 1'b1;
        gen_pkt(1, 12);
        gen_pkt(0, 8);
        predict(0);
        base = mon_beats;
        fork
            drive(0);
            drive(1);
            begin
                wait_beats(base + 4);
                sup0 = 1'b0;
            end
        join
        end_scn("suppress");

        // Random backpressure on a 16-beat packet.
        rand_ready = 1'b1;
        gen_pkt(0, 16);
        predict(-1);
        drive(0);
        rand_ready = 1'b0;
        end_scn("stall");

        // One complete packet, then reset during beat 5 of the next.
        gen_pkt(0, 4);
        predict(-1);
        drive(0);
        end_scn("pre_reset");
        gen_pkt(0, 16);
        predict(-1);
        base = mon_beats;
        fork
            drive(0);
            begin
                wait_beats(base + 4);
                abort[0] = 1'b1;
                ARESETN  = 1'b0;
                @(negedge ACLK);
                check("midpkt_reset_tvalid", m00_if.TVALID, 0);
                check("midpkt_reset_s00_tready", s00_if.TREADY, 0);
                check("midpkt_reset_cnt", {cnt1, cnt0}, 0);
                model_reset();
                repeat (2) @(posedge ACLK);
                #1;
                ARESETN = 1'b1;
            end
        join
        abort[0] = 1'b0;
        gen_pkt(0, 8);
        predict(-1);
        drive(0);
        end_scn("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
